// File: rtl/divmod_arbiter_if.sv
// Requester-side bundle of the shared divmod arbiter: operands in, ack/result pulses out.
// Zero latency (wires only); no backpressure, since every pulse is a single cycle.
// The arbiter connects to the slave modport.
interface divmod_arbiter_if #(
    parameter int N = 4,
    parameter int W = 16
);
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ack;
    logic [N-1:0]   resp_valid;
    logic [W-1:0]   resp_div;
    logic [W-1:0]   resp_mod;
    logic           resp_error;
    logic           resp_tmo;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ack, resp_valid, resp_div, resp_mod, resp_error, resp_tmo
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ack, resp_valid, resp_div, resp_mod, resp_error, resp_tmo
    );
endinterface

// File: rtl/divmod_arbiter.sv
// Round-robin arbiter sharing one divmod unit between N requesters, with a hang watchdog.
// Latency: resp_valid comes divmod latency + 3 cycles after the grant edge; at most TIMEOUT cycles after ISSUE.
// No backpressure: requesters hold req_valid until req_ack, and responses are unconditional 1-cycle pulses.
module divmod_arbiter #(
    parameter int N       = 4,
    parameter int W       = 16,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    divmod_arbiter_if.slave host,
    output logic            busy,
    output logic            dm_go,
    output logic            dm_rst,
    output logic [W-1:0]    dm_a,
    output logic [W-1:0]    dm_b,
    input  logic            dm_ready,
    input  logic            dm_error,
    input  logic [W-1:0]    dm_div,
    input  logic [W-1:0]    dm_mod
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d, id_q, id_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, div_q, div_d, mod_q, mod_d;
    logic          err_q, err_d, tmo_q, tmo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          grant_vld;
    logic [IW-1:0] grant_id;
    logic [IW-1:0] scan_idx;

    // Scan downwards so the last hit is the first set bit at or after ptr.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        scan_idx  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            scan_idx = IW'((int'(ptr_q) + i) % N);
            if (host.req_valid[scan_idx]) begin
                grant_vld = 1'b1;
                grant_id  = scan_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        div_d   = div_q;
        mod_d   = mod_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    id_d    = grant_id;
                    a_d     = host.req_a[int'(grant_id) * W +: W];
                    b_d     = host.req_b[int'(grant_id) * W +: W];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // cnt_q == 0 is the cycle where divmod is still dropping ready after go.
                if (cnt_q != '0 && dm_ready) begin
                    div_d   = dm_div;
                    mod_d   = dm_mod;
                    err_d   = dm_error;
                    tmo_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 2)) begin
                    div_d   = '0;
                    mod_d   = '0;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                ptr_d   = IW'((int'(id_q) + 1) % N);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset masks every output so nothing leaks from the state held before the reset edge.
    always_comb begin
        host.req_ack    = '0;
        host.resp_valid = '0;
        host.resp_div   = '0;
        host.resp_mod   = '0;
        host.resp_error = 1'b0;
        host.resp_tmo   = 1'b0;
        busy            = 1'b0;
        dm_go           = 1'b0;
        dm_a            = '0;
        dm_b            = '0;
        dm_rst          = rst;
        if (!rst) begin
            if (state_q != IDLE) begin
                busy = 1'b1;
                dm_a = a_q;
                dm_b = b_q;
            end
            if (state_q == ISSUE) begin
                host.req_ack[id_q] = 1'b1;
                dm_go              = 1'b1;
            end
            if (state_q == RESP) begin
                host.resp_valid[id_q] = 1'b1;
                host.resp_div         = div_q;
                host.resp_mod         = mod_q;
                host.resp_error       = err_q;
                host.resp_tmo         = tmo_q;
                dm_rst                = tmo_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            div_q   <= '0;
            mod_q   <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            div_q   <= div_d;
            mod_q   <= mod_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
